aes_link_host: RTL and testbench

- Host-side initiator for the byte-oriented AES serial link; it is the opposite end of the FPGA-side serial AES controller.
- Drives the command protocol: waits for the ready byte, sends mode, key and data commands with their 16-byte payloads, then collects the 16-byte result.
- Used by a second FPGA, or by the hardware-in-loop bench master, to drive the AES coprocessor.
- Sits between user logic and existing byte-level UART TX/RX blocks.

---
 rtl/aes_link_pkg.sv | 40 ++++
 rtl/aes_link_tx_seq.sv | 56 +++++
 rtl/aes_link_host.sv | 192 +++++++++++++++++++
 tb/tb_aes_link_host.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_link_pkg.sv
// Shared constants for both ends of the byte-oriented AES serial link.
// Command bytes, host FSM state encoding and error codes.
package aes_link_pkg;

    localparam logic [7:0] CMD_READY = 8'h52;
    localparam logic [7:0] CMD_KEY   = 8'h4B;
    localparam logic [7:0] CMD_DATA  = 8'h44;
    localparam logic [7:0] CMD_ENC   = 8'h45;
    localparam logic [7:0] CMD_DEC   = 8'h55;

    localparam int PAYLOAD_BYTES = 16;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_READY  = 2'b01;
    localparam logic [1:0] ERR_RESULT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_READY,
        S_SEND_MODE,
        S_SEND_KEY_CMD,
        S_SEND_KEY,
        S_SEND_DATA_CMD,
        S_SEND_DATA,
        S_RECV,
        S_DONE,
        S_ERROR
    } stateT;

    function automatic logic [7:0] cmdFor(input stateT st, input logic dec);
        logic [7:0] b;
        b = CMD_DATA;
        if (st == S_SEND_MODE)
            b = dec ? CMD_DEC : CMD_ENC;
        else if (st == S_SEND_KEY_CMD)
            b = CMD_KEY;
        return b;
    endfunction

endpackage

// File: rtl/aes_link_tx_seq.sv
// Serialises a 128-bit word MSB-first into 16 TxLoad/TxDone handshakes.
// Finished pulses for one cycle after the last TxDone.
module aes_link_tx_seq
    import aes_link_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Go,
    input  logic [127:0] Word,
    input  logic         TxDone,
    output logic [7:0]   TxByte,
    output logic         TxLoad,
    output logic         Finished
);

    localparam logic [3:0] LAST = 4'(PAYLOAD_BYTES - 1);

    logic [127:0] shiftReg;
    logic [3:0]   byteCnt;
    logic         active;
    logic         waiting;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            shiftReg <= '0;
            byteCnt  <= '0;
            active   <= 1'b0;
            waiting  <= 1'b0;
            TxByte   <= '0;
            TxLoad   <= 1'b0;
            Finished <= 1'b0;
        end else begin
            TxLoad   <= 1'b0;
            Finished <= 1'b0;
            if (Go) begin
                shiftReg <= Word;
                byteCnt  <= '0;
                active   <= 1'b1;
                waiting  <= 1'b0;
            end else if (active && !waiting) begin
                TxLoad  <= 1'b1;
                TxByte  <= shiftReg[127:120];
                waiting <= 1'b1;
            end else if (active && TxDone) begin
                shiftReg <= {shiftReg[119:0], 8'h00};
                waiting  <= 1'b0;
                byteCnt  <= byteCnt + 4'd1;
                if (byteCnt == LAST) begin
                    active   <= 1'b0;
                    Finished <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/aes_link_host.sv
// Host-side initiator for the AES serial link: ready, mode, key, data,
// then collects the 16-byte result over existing UART byte blocks.
module aes_link_host
    import aes_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic         LoadKey,
    input  logic         Decrypt,
    input  logic [127:0] KeyIn,
    input  logic [127:0] DataIn,
    output logic [7:0]   TxByte,
    output logic         TxLoad,
    input  logic         TxDone,
    input  logic [7:0]   RxByte,
    input  logic         RxValid,
    output logic [127:0] Result,
    output logic         Busy,
    output logic         Done,
    output logic         Error,
    output logic [1:0]   ErrCode
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] R_LAST = 4'(PAYLOAD_BYTES - 1);

    stateT        state;
    logic [127:0] keyReg;
    logic [127:0] dataReg;
    logic [119:0] rxShift;
    logic [127:0] rxNext;
    logic         loadKeyReg;
    logic         decReg;
    logic         modeKnown;
    logic         devMode;
    logic         cmdLoad;
    logic         cmdSent;
    logic [7:0]   cmdByte;
    logic         seqGo;
    logic         seqLoad;
    logic         seqFinished;
    logic [7:0]   seqByte;
    logic [3:0]   rxCnt;
    logic [TW-1:0] toCnt;
    logic         payloadPhase;

    assign payloadPhase = (state == S_SEND_KEY) || (state == S_SEND_DATA);
    assign TxLoad = cmdLoad | seqLoad;
    assign TxByte = payloadPhase ? seqByte : cmdByte;
    assign rxNext = {rxShift, RxByte};

    aes_link_tx_seq uSeq (
        .Clk      (Clk),
        .Rst      (Rst),
        .Go       (seqGo),
        .Word     ((state == S_SEND_KEY) ? keyReg : dataReg),
        .TxDone   (TxDone),
        .TxByte   (seqByte),
        .TxLoad   (seqLoad),
        .Finished (seqFinished)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= S_IDLE;
            keyReg     <= '0;
            dataReg    <= '0;
            rxShift    <= '0;
            loadKeyReg <= 1'b0;
            decReg     <= 1'b0;
            modeKnown  <= 1'b0;
            devMode    <= 1'b0;
            cmdLoad    <= 1'b0;
            cmdSent    <= 1'b0;
            cmdByte    <= '0;
            seqGo      <= 1'b0;
            rxCnt      <= '0;
            toCnt      <= '0;
            Result     <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
            ErrCode    <= ERR_NONE;
        end else begin
            cmdLoad <= 1'b0;
            seqGo   <= 1'b0;
            Done    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (Start) begin
                        keyReg     <= KeyIn;
                        dataReg    <= DataIn;
                        loadKeyReg <= LoadKey;
                        decReg     <= Decrypt;
                        Error      <= 1'b0;
                        ErrCode    <= ERR_NONE;
                        Busy       <= 1'b1;
                        toCnt      <= '0;
                        state      <= S_WAIT_READY;
                    end
                end
                S_WAIT_READY: begin
                    // A received byte always wins over the timeout boundary.
                    if (RxValid) begin
                        toCnt <= '0;
                        if (RxByte == CMD_READY) begin
                            if (!modeKnown || devMode != decReg)
                                state <= S_SEND_MODE;
                            else if (loadKeyReg)
                                state <= S_SEND_KEY_CMD;
                            else
                                state <= S_SEND_DATA_CMD;
                        end
                    end else if (toCnt == T_LAST) begin
                        state     <= S_ERROR;
                        Error     <= 1'b1;
                        ErrCode   <= ERR_READY;
                        Busy      <= 1'b0;
                        modeKnown <= 1'b0;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                S_SEND_MODE, S_SEND_KEY_CMD, S_SEND_DATA_CMD: begin
                    if (!cmdSent) begin
                        cmdLoad <= 1'b1;
                        cmdByte <= cmdFor(state, decReg);
                        cmdSent <= 1'b1;
                    end else if (TxDone) begin
                        cmdSent <= 1'b0;
                        if (state == S_SEND_MODE) begin
                            devMode   <= decReg;
                            modeKnown <= 1'b1;
                            state <= loadKeyReg ? S_SEND_KEY_CMD
                                                : S_SEND_DATA_CMD;
                        end else begin
                            seqGo <= 1'b1;
                            state <= (state == S_SEND_KEY_CMD) ? S_SEND_KEY
                                                               : S_SEND_DATA;
                        end
                    end
                end
                S_SEND_KEY: begin
                    if (seqFinished)
                        state <= S_SEND_DATA_CMD;
                end
                S_SEND_DATA: begin
                    if (seqFinished) begin
                        rxCnt <= '0;
                        toCnt <= '0;
                        state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (RxValid) begin
                        toCnt   <= '0;
                        rxShift <= rxNext[119:0];
                        rxCnt   <= rxCnt + 4'd1;
                        if (rxCnt == R_LAST) begin
                            Result <= rxNext;
                            state  <= S_DONE;
                        end
                    end else if (toCnt == T_LAST) begin
                        state     <= S_ERROR;
                        Error     <= 1'b1;
                        ErrCode   <= ERR_RESULT;
                        Busy      <= 1'b0;
                        modeKnown <= 1'b0;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                S_DONE: begin
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERROR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_link_host.sv
// Directed bench for aes_link_host with a UART/device model and
// scoreboard queues for transmitted bytes and assembled results.
module tb_aes_link_host;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         Start = 1'b0;
    logic         LoadKey = 1'b0;
    logic         Decrypt = 1'b0;
    logic [127:0] KeyIn = '0;
    logic [127:0] DataIn = '0;
    logic [7:0]   TxByte;
    logic         TxLoad;
    logic         TxDone = 1'b0;
    logic [7:0]   RxByte = '0;
    logic         RxValid = 1'b0;
    logic [127:0] Result;
    logic         Busy;
    logic         Done;
    logic         Error;
    logic [1:0]   ErrCode;

    int checks = 0;
    int errors = 0;
    int doneCnt = 0;
    logic [7:0]   expTx[$];
    logic [127:0] expRes[$];
    bit           mk = 1'b0;
    bit           dm = 1'b0;
    logic [127:0] lastRes = '0;

    localparam logic [127:0] KEY0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] DAT0 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] RES0 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

    always #5 Clk = ~Clk;

    aes_link_host #(.TIMEOUT_CYCLES(50)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Start   (Start),
        .LoadKey (LoadKey),
        .Decrypt (Decrypt),
        .KeyIn   (KeyIn),
        .DataIn  (DataIn),
        .TxByte  (TxByte),
        .TxLoad  (TxLoad),
        .TxDone  (TxDone),
        .RxByte  (RxByte),
        .RxValid (RxValid),
        .Result  (Result),
        .Busy    (Busy),
        .Done    (Done),
        .Error   (Error),
        .ErrCode (ErrCode)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // UART transmitter model: logs each loaded byte, TxDone two cycles later.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge Clk);
            if (Rst && TxLoad === 1'b1) begin
                chk("tx_queue", 128'(expTx.size() != 0), 128'd1);
                if (expTx.size() != 0) begin
                    e = expTx.pop_front();
                    chk("tx_byte", 128'(TxByte), 128'(e));
                end
                @(negedge Clk);
                if (Rst) chk("txload_pulse", 128'(TxLoad), 128'd0);
                @(negedge Clk);
                TxDone = 1'b1;
                @(negedge Clk);
                TxDone = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (Done === 1'b1) doneCnt++;
        end
    end

    task automatic sendRx(input logic [7:0] b);
        @(negedge Clk);
        RxByte  = b;
        RxValid = 1'b1;
        @(negedge Clk);
        RxValid = 1'b0;
    endtask

    task automatic pushPlan(input bit lk, input bit dec,
                            input logic [127:0] key, input logic [127:0] data);
        if (!mk || dm != dec) expTx.push_back(dec ? 8'h55 : 8'h45);
        if (lk) begin
            expTx.push_back(8'h4B);
            for (int i = 0; i < 16; i++) expTx.push_back(key[127-8*i -: 8]);
        end
        expTx.push_back(8'h44);
        for (int i = 0; i < 16; i++) expTx.push_back(data[127-8*i -: 8]);
    endtask

    task automatic doStart(input bit lk, input bit dec,
                           input logic [127:0] key, input logic [127:0] data);
        @(negedge Clk);
        Start   = 1'b1;
        LoadKey = lk;
        Decrypt = dec;
        KeyIn   = key;
        DataIn  = data;
        @(negedge Clk);
        Start = 1'b0;
        chk("busy_start", 128'(Busy), 128'd1);
        chk("err_clear", 128'({ErrCode, Error}), 128'd0);
    endtask

    task automatic waitTx();
        int n = 0;
        while (expTx.size() != 0 && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        chk("tx_all_sent", 128'(expTx.size() == 0), 128'd1);
        repeat (6) @(negedge Clk);
    endtask

    task automatic waitDone();
        int n = 0;
        while (Done !== 1'b1 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk("done_seen", 128'(Done), 128'd1);
        if (Done === 1'b1) begin
            chk("result", Result, expRes.pop_front());
            @(negedge Clk);
            chk("done_pulse", 128'(Done), 128'd0);
            chk("busy_end", 128'(Busy), 128'd0);
        end else begin
            expRes.delete();
        end
    endtask

    task automatic runTxn(input bit lk, input bit dec,
                          input logic [127:0] key, input logic [127:0] data,
                          input logic [127:0] res, input bit noise);
        int d0;
        pushPlan(lk, dec, key, data);
        doStart(lk, dec, key, data);
        if (noise) begin
            sendRx(8'h00);
            sendRx(8'h13);
        end
        sendRx(8'h52);
        waitTx();
        mk = 1'b1;
        dm = dec;
        d0 = doneCnt;
        expRes.push_back(res);
        for (int i = 0; i < 16; i++) sendRx(res[127-8*i -: 8]);
        waitDone();
        chk("done_once", 128'(doneCnt - d0), 128'd1);
        lastRes = res;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int d0;
        int n;
        logic [127:0] data;
        logic [127:0] res;

        repeat (3) @(negedge Clk);
        chk("rst_txload", 128'(TxLoad), 128'd0);
        chk("rst_txbyte", 128'(TxByte), 128'd0);
        chk("rst_flags", 128'({Busy, Done, Error, ErrCode}), 128'd0);
        chk("rst_result", Result, 128'd0);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);

        runTxn(1'b1, 1'b0, KEY0, DAT0, RES0, 1'b0);
        runTxn(1'b0, 1'b0, KEY0, rnd128(), rnd128(), 1'b0);
        runTxn(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), 1'b0);
        runTxn(1'b0, 1'b1, KEY0, rnd128(), rnd128(), 1'b0);
        runTxn(1'b0, 1'b1, KEY0, rnd128(), rnd128(), 1'b1);

        // Result timeout after 7 of 16 response bytes.
        data = rnd128();
        res  = rnd128();
        pushPlan(1'b0, 1'b0, KEY0, data);
        doStart(1'b0, 1'b0, KEY0, data);
        sendRx(8'h52);
        waitTx();
        mk = 1'b1;
        dm = 1'b0;
        d0 = doneCnt;
        for (int i = 0; i < 7; i++) sendRx(res[127-8*i -: 8]);
        repeat (49) @(negedge Clk);
        chk("err_early", 128'(Error), 128'd0);
        @(negedge Clk);
        chk("err_set", 128'(Error), 128'd1);
        chk("err_code", 128'(ErrCode), 128'd2);
        chk("err_busy", 128'(Busy), 128'd0);
        chk("err_result", Result, lastRes);
        mk = 1'b0;
        repeat (3) @(negedge Clk);
        chk("err_sticky", 128'(Error), 128'd1);
        chk("err_nodone", 128'(doneCnt - d0), 128'd0);

        runTxn(1'b0, 1'b0, KEY0, rnd128(), rnd128(), 1'b0);

        // Reset while key byte 5 is being loaded.
        data = rnd128();
        pushPlan(1'b1, 1'b0, KEY0, data);
        doStart(1'b1, 1'b0, KEY0, data);
        sendRx(8'h52);
        n = 0;
        while (!(TxLoad === 1'b1 && TxByte === 8'h05) && n < 300) begin
            @(negedge Clk);
            n++;
        end
        chk("key5_seen", 128'(n < 300), 128'd1);
        #1 Rst = 1'b0;
        #1;
        chk("arst_txload", 128'(TxLoad), 128'd0);
        chk("arst_txbyte", 128'(TxByte), 128'd0);
        chk("arst_flags", 128'({Busy, Done, Error, ErrCode}), 128'd0);
        chk("arst_result", Result, 128'd0);
        repeat (5) @(negedge Clk);
        expTx.delete();
        mk = 1'b0;
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        chk("arst_idle", 128'(Busy), 128'd0);
        runTxn(1'b0, 1'b0, KEY0, rnd128(), rnd128(), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
